// File: rtl/fetch_stage_pkg.sv
// Shared constants and the state encoding for the instruction fetch stage.
package fetch_stage_pkg;

   // Canonical RISC-V NOP (addi x0, x0, 0), shown whenever nothing valid is presented.
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // EMPTY : no valid response yet (reset and the cycle after it)
   // STREAM: the BRAM output is presented directly to decode
   // HOLD  : decode stalled, the captured instruction is presented
   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      STREAM = 2'd1,
      HOLD   = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Presentation state machine and stall hold register for the fetch stage.
// Decides what decode sees and tells the PC logic when it may advance.
module fetch_hold_buf
   import fetch_stage_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic        resp_valid,
   input  logic [31:0] resp_pc,
   input  logic        resp_misaligned,
   input  logic [31:0] imem_dout,
   output logic        pc_advance,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   output logic        inst_misaligned
);

   fetch_state_t state_reg, state_next;
   logic [31:0]  hold_inst_reg, hold_inst_next;
   logic [31:0]  hold_pc_reg, hold_pc_next;
   logic         hold_valid_reg, hold_valid_next;
   logic         hold_mis_reg, hold_mis_next;

   // State and hold register update; reset returns to EMPTY with the buffer cleared.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_reg      <= EMPTY;
         hold_inst_reg  <= NOP_INST;
         hold_pc_reg    <= 32'h0;
         hold_valid_reg <= 1'b0;
         hold_mis_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         hold_inst_reg  <= hold_inst_next;
         hold_pc_reg    <= hold_pc_next;
         hold_valid_reg <= hold_valid_next;
         hold_mis_reg   <= hold_mis_next;
      end
   end

   // Next state, hold capture, PC-advance permission and presented instruction.
   always_comb begin
      state_next      = state_reg;
      hold_inst_next  = hold_inst_reg;
      hold_pc_next    = hold_pc_reg;
      hold_valid_next = hold_valid_reg;
      hold_mis_next   = hold_mis_reg;
      pc_advance      = 1'b1;
      inst            = NOP_INST;
      inst_pc         = 32'h0;
      inst_valid      = 1'b0;
      inst_misaligned = 1'b0;

      case (state_reg)
         EMPTY: begin
            // Nothing is shown, so a stall has nothing to protect.
            state_next = STREAM;
         end
         STREAM: begin
            if (resp_valid) begin
               inst            = imem_dout;
               inst_pc         = resp_pc;
               inst_valid      = 1'b1;
               inst_misaligned = resp_misaligned;
            end
            if (stall) begin
               // The BRAM will move on next cycle, so keep a private copy.
               hold_inst_next  = imem_dout;
               hold_pc_next    = resp_pc;
               hold_valid_next = resp_valid;
               hold_mis_next   = resp_misaligned;
               pc_advance      = 1'b0;
               state_next      = HOLD;
            end
         end
         HOLD: begin
            if (hold_valid_reg) begin
               inst            = hold_inst_reg;
               inst_pc         = hold_pc_reg;
               inst_valid      = 1'b1;
               inst_misaligned = hold_mis_reg;
            end
            // fetch_pc is re-issued every held cycle, so on release its data
            // arrives exactly when STREAM resumes.
            if (stall) begin
               pc_advance = 1'b0;
            end else begin
               state_next = STREAM;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase

      // A redirect throws away whatever is held; the target arrives next cycle.
      if (redirect) begin
         state_next      = STREAM;
         hold_inst_next  = NOP_INST;
         hold_pc_next    = 32'h0;
         hold_valid_next = 1'b0;
         hold_mis_next   = 1'b0;
      end

      // Decode never sees a valid instruction while reset is held.
      if (!Reset) begin
         inst            = NOP_INST;
         inst_pc         = 32'h0;
         inst_valid      = 1'b0;
         inst_misaligned = 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect handling and the
// in-flight response tracking for a 1-cycle synchronous instruction BRAM.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          IMEM_AW  = 12
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               stall,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_dout,
   output logic [31:0]        inst,
   output logic [31:0]        inst_pc,
   output logic               inst_valid,
   output logic               inst_misaligned
);

   logic [31:0] fetch_pc_reg;
   logic [31:0] resp_pc_reg;
   logic        resp_valid_reg;
   logic        resp_mis_reg;
   logic [31:0] redirect_word;
   logic [31:0] issue_pc;
   logic        pc_advance;

   assign redirect_word = {redirect_pc[31:2], 2'b00};

   // Byte address whose word goes to the BRAM this cycle; redirect wins over sequential fetch.
   always_comb begin
      issue_pc = redirect ? redirect_word : fetch_pc_reg;
      if (!Reset) begin
         imem_addr = RESET_PC[IMEM_AW+1:2];
      end else begin
         imem_addr = issue_pc[IMEM_AW+1:2];
      end
   end

   // PC and in-flight response tracking; the +4 wraps naturally at 2^32.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         fetch_pc_reg   <= RESET_PC;
         resp_pc_reg    <= 32'h0;
         resp_valid_reg <= 1'b0;
         resp_mis_reg   <= 1'b0;
      end else begin
         resp_pc_reg    <= issue_pc;
         resp_valid_reg <= 1'b1;
         resp_mis_reg   <= redirect && (redirect_pc[1:0] != 2'b00);
         if (redirect) begin
            fetch_pc_reg <= redirect_word + 32'd4;
         end else if (pc_advance) begin
            fetch_pc_reg <= fetch_pc_reg + 32'd4;
         end
      end
   end

   fetch_hold_buf u_hold_buf (
      .Clock           (Clock),
      .Reset           (Reset),
      .stall           (stall),
      .redirect        (redirect),
      .resp_valid      (resp_valid_reg),
      .resp_pc         (resp_pc_reg),
      .resp_misaligned (resp_mis_reg),
      .imem_dout       (imem_dout),
      .pc_advance      (pc_advance),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .inst_valid      (inst_valid),
      .inst_misaligned (inst_misaligned)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a BRAM with M[i]=i, a decode-view model of the
// instruction stream, and directed plus randomised stall/redirect traffic.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [11:0] imem_addr;
   logic [31:0] imem_dout;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_misaligned;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(TB_RESET_PC), .IMEM_AW(12)) dut (
      .Clock           (clk),
      .Reset           (rst_n),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_addr       (imem_addr),
      .imem_dout       (imem_dout),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .inst_valid      (inst_valid),
      .inst_misaligned (inst_misaligned)
   );

   // Instruction BRAM with a registered read.
   logic [31:0] mem [0:4095];
   always @(posedge clk) imem_dout <= mem[imem_addr];

   int checks = 0;
   int failures = 0;

   // Decode-view model: what instruction decode must currently be looking at.
   logic        m_valid = 1'b0;
   logic [31:0] m_pc = 32'h0;
   logic        m_mis = 1'b0;
   logic [31:0] m_seq = TB_RESET_PC;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock of stimulus, then a model update and a full output comparison.
   task automatic cyc(input logic r, input logic s, input logic d, input logic [31:0] p);
      logic [31:0] exp_inst;
      rst_n = r; stall = s; redirect = d; redirect_pc = p;
      @(posedge clk);
      if (!r) begin
         m_valid = 1'b0; m_pc = 32'h0; m_mis = 1'b0; m_seq = TB_RESET_PC;
      end else if (d) begin
         m_pc = {p[31:2], 2'b00}; m_valid = 1'b1; m_mis = (p[1:0] != 2'b00); m_seq = m_pc + 32'd4;
      end else if (!m_valid || !s) begin
         m_pc = m_seq; m_valid = 1'b1; m_mis = 1'b0; m_seq = m_seq + 32'd4;
      end
      @(negedge clk);
      exp_inst = m_valid ? mem[m_pc[13:2]] : NOP_INST;
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
      chk("inst_pc", inst_pc, m_valid ? m_pc : 32'h0);
      chk("inst", inst, exp_inst);
      chk("inst_misaligned", {31'b0, inst_misaligned}, {31'b0, m_mis & m_valid});
      $display("cyc rst_n=%0b stall=%0b redir=%0b rpc=%h -> valid=%0b pc=%h inst=%h mis=%0b",
               r, s, d, p, inst_valid, inst_pc, inst, inst_misaligned);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = i;
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

      // Reset state
      cyc(0, 0, 0, 32'h0);
      cyc(0, 1, 1, 32'h0000_0500);
      chk("reset_valid", {31'b0, inst_valid}, 32'h0);
      chk("reset_inst", inst, 32'h0000_0013);
      chk("reset_addr", {20'b0, imem_addr}, 32'h0);

      // Streaming from reset
      cyc(1, 0, 0, 32'h0);
      chk("first_pc", inst_pc, 32'h0);
      chk("first_addr", {20'b0, imem_addr}, 32'h1);
      cyc(1, 0, 0, 32'h0);
      chk("second_inst", inst, 32'h1);
      cyc(1, 0, 0, 32'h0);
      chk("third_pc", inst_pc, 32'h8);

      // Three-cycle stall on pc 0x8
      cyc(1, 1, 0, 32'h0);
      cyc(1, 1, 0, 32'h0);
      cyc(1, 1, 0, 32'h0);
      chk("held_pc", inst_pc, 32'h8);
      cyc(1, 0, 0, 32'h0);
      chk("after_stall_pc", inst_pc, 32'hC);
      cyc(1, 0, 0, 32'h0);
      chk("after_stall_pc2", inst_pc, 32'h10);

      // Redirect while streaming 0x20
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 32'h0);
      chk("stream_pc_20", inst_pc, 32'h20);
      cyc(1, 0, 1, 32'h0000_0100);
      chk("redirect_pc", inst_pc, 32'h100);
      chk("redirect_inst", inst, 32'h40);
      cyc(1, 0, 0, 32'h0);
      chk("redirect_next_pc", inst_pc, 32'h104);

      // Redirect during a stall drops the held instruction
      cyc(1, 1, 0, 32'h0);
      cyc(1, 1, 0, 32'h0);
      cyc(1, 1, 1, 32'h0000_0040);
      chk("stall_redirect_pc", inst_pc, 32'h40);

      // Stall releases on the same cycle as a redirect
      cyc(1, 1, 0, 32'h0);
      cyc(1, 0, 1, 32'h0000_0300);
      chk("release_redirect_pc", inst_pc, 32'h300);

      // Misaligned redirect target
      cyc(1, 0, 1, 32'h0000_0202);
      chk("mis_pc", inst_pc, 32'h200);
      chk("mis_flag", {31'b0, inst_misaligned}, 32'h1);
      cyc(1, 0, 0, 32'h0);
      chk("mis_next_pc", inst_pc, 32'h204);
      chk("mis_next_flag", {31'b0, inst_misaligned}, 32'h0);
      cyc(1, 0, 1, 32'h0000_0207);
      cyc(1, 1, 0, 32'h0);
      cyc(1, 1, 0, 32'h0);
      cyc(1, 0, 0, 32'h0);

      // Reset during HOLD with a competing redirect
      cyc(1, 1, 0, 32'h0);
      cyc(1, 1, 0, 32'h0);
      cyc(0, 1, 1, 32'h0000_0500);
      chk("hold_reset_valid", {31'b0, inst_valid}, 32'h0);
      chk("hold_reset_inst", inst, 32'h0000_0013);
      cyc(1, 0, 0, 32'h0);
      chk("post_reset_pc", inst_pc, TB_RESET_PC);

      // Wrap at 2^32
      cyc(1, 0, 1, 32'hFFFF_FFF8);
      chk("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
      chk("wrap_inst0", inst, 32'h0000_0FFE);
      cyc(1, 0, 0, 32'h0);
      cyc(1, 0, 0, 32'h0);
      chk("wrap_pc", inst_pc, 32'h0);

      // Mixed traffic against the model
      for (int i = 0; i < 80; i++) begin
         cyc(($urandom_range(0, 29) != 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 7) == 0), ($urandom() & 32'h0000_3FFF));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
